sweep_controller: RTL and testbench

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

---
 rtl/sound_pkg.sv | 27 ++
 rtl/sweep_calc.sv | 18 +
 rtl/sweep_controller.sv | 135 +++++++++++++
 tb/tb_sweep_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound channel blocks.
package sound_pkg;

  localparam int FREQ_W   = 11;
  localparam int PERIOD_W = 17;
  localparam logic [FREQ_W:0] FREQ_MAX = 12'd2047;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CALC,
    CHECK,
    DISABLED
  } sweep_state_t;

  // Timer period for a frequency register value: (2048 - f) * 4, zero-extended.
  function automatic logic [PERIOD_W-1:0] calc_period(input logic [FREQ_W-1:0] f);
    logic [FREQ_W:0] diff;
    diff = 12'd2048 - {1'b0, f};
    return {{(PERIOD_W - FREQ_W - 3){1'b0}}, diff, 2'b00};
  endfunction

  function automatic logic [3:0] timer_reload(input logic [2:0] p);
    return (p == 3'd0) ? 4'd8 : {1'b0, p};
  endfunction

endpackage

// File: rtl/sweep_calc.sv
// Combinational sweep step: new frequency = shadow +/- (shadow >> shift), 12-bit result.
module sweep_calc
  import sound_pkg::*;
(
  input  logic [FREQ_W-1:0] i_shadow,
  input  logic [2:0]        i_shift,
  input  logic              i_negate,
  output logic [FREQ_W:0]   o_new_freq
);

  logic [FREQ_W-1:0] w_delta;

  assign w_delta    = i_shadow >> i_shift;
  // delta never exceeds shadow, so the subtract cannot wrap.
  assign o_new_freq = i_negate ? ({1'b0, i_shadow} - {1'b0, w_delta})
                               : ({1'b0, i_shadow} + {1'b0, w_delta});

endmodule

// File: rtl/sweep_controller.sv
// Frequency sweep controller for a square channel.
// Optional SWEEP_INIT_CHECK_EN: overflow-only check right after a trigger with nonzero shift.
module sweep_controller
  import sound_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger,
  input  logic [FREQ_W-1:0]   freq_in,
  input  logic [2:0]          sweep_period,
  input  logic                sweep_negate,
  input  logic [2:0]          sweep_shift,
  input  logic                sweep_tick,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_update,
  output logic                channel_disable
);

  sweep_state_t        r_state, w_state_next;
  logic [FREQ_W-1:0]   r_shadow, w_shadow_next;
  logic [3:0]          r_timer, w_timer_next;
  logic                r_enabled, w_enabled_next;
  logic [PERIOD_W-1:0] r_period, w_period_next;
  logic                r_update, w_update_next;
  logic                r_disable, w_disable_next;
  logic [FREQ_W:0]     r_new_freq, w_new_freq_next;
  logic                r_load, w_load_next;
  logic                r_init, w_init_next;
  logic [FREQ_W:0]     w_calc;

  sweep_calc u_calc (
    .i_shadow   (r_shadow),
    .i_shift    (sweep_shift),
    .i_negate   (sweep_negate),
    .o_new_freq (w_calc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_timer    <= '0;
      r_enabled  <= 1'b0;
      r_period   <= '0;
      r_update   <= 1'b0;
      r_disable  <= 1'b0;
      r_new_freq <= '0;
      r_load     <= 1'b0;
      r_init     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shadow   <= w_shadow_next;
      r_timer    <= w_timer_next;
      r_enabled  <= w_enabled_next;
      r_period   <= w_period_next;
      r_update   <= w_update_next;
      r_disable  <= w_disable_next;
      r_new_freq <= w_new_freq_next;
      r_load     <= w_load_next;
      r_init     <= w_init_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shadow_next   = r_shadow;
    w_timer_next    = r_timer;
    w_enabled_next  = r_enabled;
    w_period_next   = r_period;
    w_update_next   = 1'b0;
    w_disable_next  = r_disable;
    w_new_freq_next = r_new_freq;
    w_load_next     = 1'b0;
    w_init_next     = r_init;

    if (trigger) begin
      w_shadow_next  = freq_in;
      w_timer_next   = timer_reload(sweep_period);
      w_enabled_next = (sweep_period != 3'd0) || (sweep_shift != 3'd0);
      w_disable_next = 1'b0;
      w_state_next   = RUN;
      w_load_next    = 1'b1;
`ifdef SWEEP_INIT_CHECK_EN
      w_init_next    = (sweep_shift != 3'd0);
`else
      w_init_next    = 1'b0;
`endif
    end else begin
      // Period from a fresh trigger is published one edge after the shadow load.
      if (r_load) begin
        w_period_next = calc_period(r_shadow);
        w_update_next = 1'b1;
      end
      case (r_state)
        RUN: begin
          if (r_init) begin
            w_state_next = CALC;
          end else if (sweep_tick) begin
            if (r_timer == 4'd1) begin
              w_timer_next = timer_reload(sweep_period);
              if (r_enabled && (sweep_period != 3'd0))
                w_state_next = CALC;
            end else begin
              w_timer_next = r_timer - 4'd1;
            end
          end
        end
        CALC: begin
          w_new_freq_next = w_calc;
          w_state_next    = CHECK;
        end
        CHECK: begin
          w_init_next = 1'b0;
          if (r_new_freq > FREQ_MAX) begin
            w_state_next   = DISABLED;
            w_disable_next = 1'b1;
          end else begin
            w_state_next = RUN;
            if (!r_init && (sweep_shift != 3'd0)) begin
              w_shadow_next = r_new_freq[FREQ_W-1:0];
              w_period_next = calc_period(r_new_freq[FREQ_W-1:0]);
              w_update_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign period_out      = r_period;
  assign period_update   = r_update;
  assign channel_disable = r_disable;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed self-checking bench for sweep_controller (default build).
module tb_sweep_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        trigger;
  logic [10:0] freq_in;
  logic [2:0]  sweep_period;
  logic        sweep_negate;
  logic [2:0]  sweep_shift;
  logic        sweep_tick;
  logic [16:0] period_out;
  logic        period_update;
  logic        channel_disable;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;
  int mark;

  sweep_controller dut (
    .clock           (clock),
    .reset           (reset),
    .trigger         (trigger),
    .freq_in         (freq_in),
    .sweep_period    (sweep_period),
    .sweep_negate    (sweep_negate),
    .sweep_shift     (sweep_shift),
    .sweep_tick      (sweep_tick),
    .period_out      (period_out),
    .period_update   (period_update),
    .channel_disable (channel_disable)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (period_update) upd_cnt <= upd_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_trigger(input logic [10:0] f, input logic [2:0] p,
                            input logic neg, input logic [2:0] sh);
    freq_in = f; sweep_period = p; sweep_negate = neg; sweep_shift = sh;
    trigger = 1'b1;
    @(posedge clock); #1;
    trigger = 1'b0;
  endtask

  task automatic do_tick();
    sweep_tick = 1'b1;
    @(posedge clock); #1;
    sweep_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trigger = 1'b0; freq_in = '0; sweep_period = '0;
    sweep_negate = 1'b0; sweep_shift = '0; sweep_tick = 1'b0;
    wait_cycles(3);
    check_val("rst_period", period_out, 0);
    check_val("rst_update", period_update, 0);
    check_val("rst_disable", channel_disable, 0);
    check_val("rst_state", dut.r_state, 0);
    reset = 1'b0;
    wait_cycles(2);

    // Add sweep: 0x400 -> 0x600
    do_trigger(11'h400, 3'd1, 1'b0, 3'd1);
    check_val("A_no_early_upd", period_update, 0);
    wait_cycles(1);
    check_val("A_load_period", period_out, 4096);
    check_val("A_load_upd", period_update, 1);
    wait_cycles(1);
    check_val("A_upd_one_cycle", period_update, 0);
    do_tick();
    wait_cycles(1);
    check_val("A_not_yet", period_out, 4096);
    wait_cycles(1);
    check_val("A_step_period", period_out, 2048);
    check_val("A_step_upd", period_update, 1);
    check_val("A_shadow", dut.r_shadow, 11'h600);

    // Overflow: 0x700 + 0x380 > 2047
    wait_cycles(2);
    do_trigger(11'h700, 3'd1, 1'b0, 3'd1);
    wait_cycles(1);
    check_val("B_load_period", period_out, 1024);
    do_tick();
    wait_cycles(3);
    check_val("B_disable", channel_disable, 1);
    check_val("B_period_kept", period_out, 1024);
    mark = upd_cnt;
    for (int i = 0; i < 3; i++) begin do_tick(); wait_cycles(2); end
    check_val("B_ticks_ignored", upd_cnt - mark, 0);
    check_val("B_still_disabled", channel_disable, 1);

    // Negate sweep with period 2: 0x400 -> 0x300 on second tick
    do_trigger(11'h400, 3'd2, 1'b1, 3'd2);
    check_val("C_disable_cleared", channel_disable, 0);
    wait_cycles(1);
    check_val("C_load_period", period_out, 4096);
    wait_cycles(1);
    mark = upd_cnt;
    do_tick();
    wait_cycles(3);
    check_val("C_tick1_noop", upd_cnt - mark, 0);
    do_tick();
    wait_cycles(3);
    check_val("C_tick2_period", period_out, 5120);
    check_val("C_tick2_upd", upd_cnt - mark, 1);

    // Sweep period 0: no steps
    do_trigger(11'h200, 3'd0, 1'b0, 3'd3);
    wait_cycles(2);
    check_val("D_load_period", period_out, 6144);
    mark = upd_cnt;
    for (int i = 0; i < 20; i++) begin do_tick(); wait_cycles(1); end
    check_val("D_no_updates", upd_cnt - mark, 0);

    // Retrigger during CALC aborts the step
    do_trigger(11'h400, 3'd1, 1'b0, 3'd1);
    wait_cycles(2);
    do_tick();
    check_val("E_in_calc", dut.r_state, 2);
    mark = upd_cnt;
    do_trigger(11'h100, 3'd1, 1'b0, 3'd1);
    wait_cycles(1);
    check_val("E_period", period_out, 7168);
    wait_cycles(3);
    check_val("E_period_kept", period_out, 7168);
    check_val("E_disable", channel_disable, 0);
    check_val("E_one_update", upd_cnt - mark, 1);

    // Reset during CALC discards the result
    do_trigger(11'h400, 3'd1, 1'b0, 3'd1);
    wait_cycles(2);
    do_tick();
    mark = upd_cnt;
    #2 reset = 1'b1;
    #1 check_val("F_async_period", period_out, 0);
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(4);
    check_val("F_no_update", upd_cnt - mark, 0);
    check_val("F_period", period_out, 0);
    check_val("F_state", dut.r_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
